// File: rtl/dot_product_accum.sv
// Sums LEN consecutive unsigned products from the multiplier stream into one
// saturating dot-product result, presented on a valid/ready port.
module dot_product_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int LEN       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2*WIDTH-1:0]         product_in,
  input  logic                       prod_valid,
  output logic                       busy,
  output logic [$clog2(LEN+1)-1:0]   count,
  output logic [ACC_WIDTH-1:0]       acc_out,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic                       overflow,
  output logic                       drop_err,
  output logic [1:0]                 state_dbg
);

  localparam int CNT_W = $clog2(LEN+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN-1);

  // Handshake: acc_out/overflow transfer on a cycle where acc_valid && acc_ready;
  // once raised, acc_valid and its payload stay stable until that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic                 sum_carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  // A carry out of the accumulator width means saturation; an already
  // saturated accumulator carries on any nonzero add and so stays saturated.
  always_comb begin
    sum       = {1'b0, acc_q} + (ACC_WIDTH+1)'(product_in);
    sum_carry = sum[ACC_WIDTH];
    acc_sat   = sum_carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    valid_d   = valid_q;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (prod_valid) drop_d = 1'b1;
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (prod_valid) begin
          acc_d = acc_sat;
          ovf_d = ovf_q | sum_carry;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d   = HOLD;
            out_d     = acc_sat;
            out_ovf_d = ovf_q | sum_carry;
            valid_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (prod_valid) drop_d = 1'b1;
        if (valid_q && acc_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == ACCUM);
  assign count     = cnt_q;
  assign acc_out   = out_q;
  assign acc_valid = valid_q;
  assign overflow  = out_ovf_q;
  assign drop_err  = drop_q;
  assign state_dbg = state_q;

endmodule
